// File: rtl/aud_pkg.sv
// Shared state encoding and bus defaults for the audio record/playback SRAM arbiter.
package aud_pkg;

    localparam int AUD_ADDR_W = 20;
    localparam int AUD_DATA_W = 16;
    localparam logic [AUD_ADDR_W-1:0] AUD_MAX_ADDR = 20'hFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_REC_PAUSE  = 3'd2,
        ST_PLAY       = 3'd3,
        ST_PLAY_PAUSE = 3'd4
    } aud_state_e;

endpackage

// File: rtl/aud_sram_port.sv
// SRAM bus sequencer: a write request gives one cycle of we_n low, a read request
// one cycle of oe_n low, with the read word and ack registered one cycle after that.
module aud_sram_port #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              we_n_reg;
    logic              oe_n_reg;
    logic              ack_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            we_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            ack_reg   <= 1'b0;
        end else begin
            // Writes win if both are ever requested, so the strobes stay exclusive.
            we_n_reg <= ~wr_req;
            oe_n_reg <= ~(rd_req & ~wr_req);
            if (wr_req) begin
                addr_reg  <= wr_addr;
                wdata_reg <= wr_data;
            end else if (rd_req) begin
                addr_reg <= rd_addr;
            end
            ack_reg <= ~oe_n_reg;
            if (!oe_n_reg) begin
                rdata_reg <= sram_rdata;
            end
        end
    end

    assign sram_addr  = addr_reg;
    assign sram_wdata = wdata_reg;
    assign sram_we_n  = we_n_reg;
    assign sram_oe_n  = oe_n_reg;
    assign rd_ack     = ack_reg;
    assign rd_data    = rdata_reg;
    assign rd_busy    = ~oe_n_reg;

endmodule

// File: rtl/aud_sram_arbiter.sv
// Record/playback controller: decodes user keys, emits recorder/player command
// pulses and arbitrates the single-port SRAM between recorder writes and player reads.
module aud_sram_arbiter
    import aud_pkg::*;
#(
    parameter int                ADDR_W   = AUD_ADDR_W,
    parameter int                DATA_W   = AUD_DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(AUD_MAX_ADDR)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_data,
    input  logic              i_play_req,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic              o_play_ack,
    output logic [DATA_W-1:0] o_play_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic [2:0]        o_state
);

    aud_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] prev_addr_reg;
    logic [ADDR_W-1:0] end_addr_reg, end_addr_next;
    logic              wr_last_reg, wr_last_next;
    logic              rec_start_reg, rec_start_next;
    logic              rec_pause_reg, rec_pause_next;
    logic              rec_stop_reg, rec_stop_next;
    logic              play_start_reg, play_start_next;
    logic              play_pause_reg, play_pause_next;
    logic              play_stop_reg, play_stop_next;

    logic key_stop, key_pause, key_rec, key_play;
    logic rec_mode, wr_req, rd_req, rd_busy, in_range;

    // Priority: stop > pause > rec/play; rec together with play cancels both.
    assign key_stop  = i_key_stop;
    assign key_pause = i_key_pause & ~i_key_stop;
    assign key_rec   = i_key_rec & ~i_key_play & ~i_key_stop & ~i_key_pause;
    assign key_play  = i_key_play & ~i_key_rec & ~i_key_stop & ~i_key_pause;

    assign rec_mode = (state_reg == ST_REC) || (state_reg == ST_REC_PAUSE);
    // A recorder address step means the word at the old address is complete.
    assign wr_req   = rec_mode && (i_rec_addr != prev_addr_reg) && !key_stop && !wr_last_reg;
    assign wr_last_next = wr_req && (prev_addr_reg == MAX_ADDR);

    assign in_range = i_play_addr < end_addr_reg;
    assign rd_req   = (state_reg == ST_PLAY) && i_play_req && !rd_busy
                      && !i_key_stop && !i_key_pause && in_range;

    always_comb begin
        state_next      = state_reg;
        end_addr_next   = end_addr_reg;
        rec_start_next  = 1'b0;
        rec_pause_next  = 1'b0;
        rec_stop_next   = 1'b0;
        play_start_next = 1'b0;
        play_pause_next = 1'b0;
        play_stop_next  = 1'b0;

        if (wr_req) begin
            end_addr_next = i_rec_addr;
        end

        case (state_reg)
            ST_IDLE: begin
                if (key_rec) begin
                    state_next     = ST_REC;
                    rec_start_next = 1'b1;
                    end_addr_next  = '0;
                end else if (key_play && (end_addr_reg != '0)) begin
                    state_next      = ST_PLAY;
                    play_start_next = 1'b1;
                end
            end
            ST_REC, ST_REC_PAUSE: begin
                // wr_last_reg: the MAX_ADDR write is on the bus this cycle.
                if (key_stop || wr_last_reg) begin
                    state_next    = ST_IDLE;
                    rec_stop_next = 1'b1;
                end else if (state_reg == ST_REC && key_pause) begin
                    state_next     = ST_REC_PAUSE;
                    rec_pause_next = 1'b1;
                end else if (state_reg == ST_REC_PAUSE && key_rec) begin
                    state_next     = ST_REC;
                    rec_start_next = 1'b1;
                end
            end
            ST_PLAY: begin
                if (key_stop) begin
                    state_next     = ST_IDLE;
                    play_stop_next = 1'b1;
                end else if (key_pause) begin
                    state_next      = ST_PLAY_PAUSE;
                    play_pause_next = 1'b1;
                end else if (i_play_req && !rd_busy && !in_range) begin
                    state_next     = ST_IDLE;
                    play_stop_next = 1'b1;
                end
            end
            ST_PLAY_PAUSE: begin
                if (key_stop) begin
                    state_next     = ST_IDLE;
                    play_stop_next = 1'b1;
                end else if (key_play) begin
                    state_next      = ST_PLAY;
                    play_start_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            prev_addr_reg  <= '0;
            end_addr_reg   <= '0;
            wr_last_reg    <= 1'b0;
            rec_start_reg  <= 1'b0;
            rec_pause_reg  <= 1'b0;
            rec_stop_reg   <= 1'b0;
            play_start_reg <= 1'b0;
            play_pause_reg <= 1'b0;
            play_stop_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prev_addr_reg  <= i_rec_addr;
            end_addr_reg   <= end_addr_next;
            wr_last_reg    <= wr_last_next;
            rec_start_reg  <= rec_start_next;
            rec_pause_reg  <= rec_pause_next;
            rec_stop_reg   <= rec_stop_next;
            play_start_reg <= play_start_next;
            play_pause_reg <= play_pause_next;
            play_stop_reg  <= play_stop_next;
        end
    end

    aud_sram_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .wr_req     (wr_req),
        .wr_addr    (prev_addr_reg),
        .wr_data    (i_rec_data),
        .rd_req     (rd_req),
        .rd_addr    (i_play_addr),
        .sram_rdata (i_sram_rdata),
        .sram_addr  (o_sram_addr),
        .sram_wdata (o_sram_wdata),
        .sram_we_n  (o_sram_we_n),
        .sram_oe_n  (o_sram_oe_n),
        .rd_ack     (o_play_ack),
        .rd_data    (o_play_data),
        .rd_busy    (rd_busy)
    );

    assign o_rec_start  = rec_start_reg;
    assign o_rec_pause  = rec_pause_reg;
    assign o_rec_stop   = rec_stop_reg;
    assign o_play_start = play_start_reg;
    assign o_play_pause = play_pause_reg;
    assign o_play_stop  = play_stop_reg;
    assign o_end_addr   = end_addr_reg;
    assign o_state      = state_reg;

endmodule

// File: tb/tb_aud_sram_arbiter.sv
// Directed bench for aud_sram_arbiter: record, pause, playback, bounds, auto-stop and reset.
`timescale 1ns/1ps
module tb_aud_sram_arbiter;
    import aud_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_key_rec = 1'b0, i_key_play = 1'b0, i_key_pause = 1'b0, i_key_stop = 1'b0;
    logic [AW-1:0] i_rec_addr = '0;
    logic [DW-1:0] i_rec_data = '0;
    logic          i_play_req = 1'b0;
    logic [AW-1:0] i_play_addr = '0;
    logic          o_rec_start, o_rec_pause, o_rec_stop;
    logic          o_play_start, o_play_pause, o_play_stop;
    logic          o_play_ack;
    logic [DW-1:0] o_play_data;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] o_sram_wdata;
    logic [DW-1:0] i_sram_rdata;
    logic          o_sram_we_n, o_sram_oe_n;
    logic [AW-1:0] o_end_addr;
    logic [2:0]    o_state;
    logic [5:0]    pulses;

    int n_vec = 0;
    int n_err = 0;
    int overlap_cnt = 0;

    logic [DW-1:0] mem [16];

    aud_sram_arbiter dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_key_rec    (i_key_rec),
        .i_key_play   (i_key_play),
        .i_key_pause  (i_key_pause),
        .i_key_stop   (i_key_stop),
        .i_rec_addr   (i_rec_addr),
        .i_rec_data   (i_rec_data),
        .i_play_req   (i_play_req),
        .i_play_addr  (i_play_addr),
        .o_rec_start  (o_rec_start),
        .o_rec_pause  (o_rec_pause),
        .o_rec_stop   (o_rec_stop),
        .o_play_start (o_play_start),
        .o_play_pause (o_play_pause),
        .o_play_stop  (o_play_stop),
        .o_play_ack   (o_play_ack),
        .o_play_data  (o_play_data),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (i_sram_rdata),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_oe_n  (o_sram_oe_n),
        .o_end_addr   (o_end_addr),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    // {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}
    assign pulses = {o_rec_start, o_rec_pause, o_rec_stop, o_play_start, o_play_pause, o_play_stop};

    // Small SRAM stand-in: low address bits only, asynchronous read while oe_n is low.
    always @(posedge i_clk) if (!o_sram_we_n) mem[o_sram_addr[3:0]] <= o_sram_wdata;
    assign i_sram_rdata = o_sram_oe_n ? '0 : mem[o_sram_addr[3:0]];

    always @(negedge i_clk) begin
        if (!o_sram_we_n) $display("sram write addr=%h data=%h", o_sram_addr, o_sram_wdata);
        if (!o_sram_oe_n) $display("sram read  addr=%h", o_sram_addr);
        if (o_play_ack)   $display("play ack   data=%h", o_play_data);
        if (!o_sram_we_n && !o_sram_oe_n) overlap_cnt++;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_keys();
        i_key_rec = 1'b0; i_key_play = 1'b0; i_key_pause = 1'b0; i_key_stop = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        n_vec++; if (o_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d exp 0", o_state); end
        n_vec++; if ({o_sram_we_n, o_sram_oe_n} !== 2'b11) begin n_err++; $display("FAIL rst_strobes: got %b exp 11", {o_sram_we_n, o_sram_oe_n}); end
        n_vec++; if (pulses !== 6'b0 || o_play_ack !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got %b/%b exp 0/0", pulses, o_play_ack); end
        n_vec++; if (o_end_addr !== '0 || o_sram_addr !== '0 || o_sram_wdata !== '0 || o_play_data !== '0) begin
            n_err++; $display("FAIL rst_busses: end=%h addr=%h wdata=%h pdata=%h exp all 0", o_end_addr, o_sram_addr, o_sram_wdata, o_play_data);
        end
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_record();
        i_rec_addr = 20'd0;
        i_key_rec = 1'b1;
        step(); clear_keys();
        n_vec++; if (pulses !== 6'b100000) begin n_err++; $display("FAIL rec_start_pulse: got %b exp 100000", pulses); end
        n_vec++; if (o_state !== ST_REC) begin n_err++; $display("FAIL rec_state: got %0d exp 1", o_state); end
        i_rec_addr = 20'd1; i_rec_data = 16'hA5A5;
        step();
        n_vec++; if (pulses !== 6'b0) begin n_err++; $display("FAIL rec_start_width: got %b exp 000000", pulses); end
        n_vec++; if (o_sram_we_n !== 1'b0 || o_sram_addr !== 20'd0 || o_sram_wdata !== 16'hA5A5) begin
            n_err++; $display("FAIL rec_wr0: we_n=%b addr=%h data=%h exp 0/00000/a5a5", o_sram_we_n, o_sram_addr, o_sram_wdata);
        end
        n_vec++; if (o_end_addr !== 20'd1) begin n_err++; $display("FAIL rec_end1: got %h exp 1", o_end_addr); end
        i_rec_addr = 20'd2; i_rec_data = 16'h5A5A;
        step();
        n_vec++; if (o_sram_we_n !== 1'b0 || o_sram_addr !== 20'd1 || o_sram_wdata !== 16'h5A5A) begin
            n_err++; $display("FAIL rec_wr1: we_n=%b addr=%h data=%h exp 0/00001/5a5a", o_sram_we_n, o_sram_addr, o_sram_wdata);
        end
        step();
        n_vec++; if (o_sram_we_n !== 1'b1) begin n_err++; $display("FAIL rec_we_release: got %b exp 1", o_sram_we_n); end
        n_vec++; if (o_end_addr !== 20'd2) begin n_err++; $display("FAIL rec_end2: got %h exp 2", o_end_addr); end
    endtask

    task automatic test_pause();
        i_key_pause = 1'b1;
        step(); clear_keys();
        n_vec++; if (pulses !== 6'b010000) begin n_err++; $display("FAIL pause_pulse: got %b exp 010000", pulses); end
        n_vec++; if (o_state !== ST_REC_PAUSE) begin n_err++; $display("FAIL pause_state: got %0d exp 2", o_state); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (o_sram_we_n !== 1'b1 || pulses !== 6'b0) begin n_err++; $display("FAIL pause_idle%0d: we_n=%b pulses=%b exp 1/000000", i, o_sram_we_n, pulses); end
        end
        n_vec++; if (o_end_addr !== 20'd2) begin n_err++; $display("FAIL pause_end: got %h exp 2", o_end_addr); end
        i_key_rec = 1'b1;
        step(); clear_keys();
        n_vec++; if (pulses !== 6'b100000 || o_state !== ST_REC) begin n_err++; $display("FAIL resume: pulses=%b state=%0d exp 100000/1", pulses, o_state); end
        i_key_stop = 1'b1;
        step(); clear_keys();
        n_vec++; if (pulses !== 6'b001000 || o_state !== ST_IDLE) begin n_err++; $display("FAIL rec_stop: pulses=%b state=%0d exp 001000/0", pulses, o_state); end
        n_vec++; if (o_end_addr !== 20'd2) begin n_err++; $display("FAIL stop_end: got %h exp 2", o_end_addr); end
    endtask

    task automatic test_play();
        i_key_play = 1'b1;
        step(); clear_keys();
        n_vec++; if (pulses !== 6'b000100 || o_state !== ST_PLAY) begin n_err++; $display("FAIL play_start: pulses=%b state=%0d exp 000100/3", pulses, o_state); end
        i_play_req = 1'b1; i_play_addr = 20'd0;
        step();
        n_vec++; if (o_sram_oe_n !== 1'b0 || o_sram_addr !== 20'd0 || o_play_ack !== 1'b0) begin
            n_err++; $display("FAIL rd0_strobe: oe_n=%b addr=%h ack=%b exp 0/00000/0", o_sram_oe_n, o_sram_addr, o_play_ack);
        end
        n_vec++; if (o_sram_we_n !== 1'b1) begin n_err++; $display("FAIL rd0_we: got %b exp 1", o_sram_we_n); end
        i_play_req = 1'b0;
        step();
        n_vec++; if (o_play_ack !== 1'b1 || o_play_data !== 16'hA5A5 || o_sram_oe_n !== 1'b1) begin
            n_err++; $display("FAIL rd0_ack: ack=%b data=%h oe_n=%b exp 1/a5a5/1", o_play_ack, o_play_data, o_sram_oe_n);
        end
        // Second request stays high into the outstanding cycle and must be dropped.
        i_play_req = 1'b1; i_play_addr = 20'd1;
        step();
        n_vec++; if (o_sram_oe_n !== 1'b0 || o_sram_addr !== 20'd1) begin n_err++; $display("FAIL rd1_strobe: oe_n=%b addr=%h exp 0/00001", o_sram_oe_n, o_sram_addr); end
        i_play_addr = 20'd0;
        step();
        n_vec++; if (o_play_ack !== 1'b1 || o_play_data !== 16'h5A5A) begin n_err++; $display("FAIL rd1_ack: ack=%b data=%h exp 1/5a5a", o_play_ack, o_play_data); end
        n_vec++; if (o_sram_oe_n !== 1'b1) begin n_err++; $display("FAIL rd_busy_ignore: oe_n=%b exp 1", o_sram_oe_n); end
        i_play_req = 1'b0;
        step();
        n_vec++; if (o_play_ack !== 1'b0) begin n_err++; $display("FAIL rd_single_ack: got %b exp 0", o_play_ack); end
        i_play_req = 1'b1; i_play_addr = 20'd2;
        step();
        i_play_req = 1'b0;
        n_vec++; if (pulses !== 6'b000001 || o_state !== ST_IDLE) begin n_err++; $display("FAIL rd_oob_stop: pulses=%b state=%0d exp 000001/0", pulses, o_state); end
        n_vec++; if (o_sram_oe_n !== 1'b1) begin n_err++; $display("FAIL rd_oob_noaccess: oe_n=%b exp 1", o_sram_oe_n); end
        step();
        n_vec++; if (o_play_ack !== 1'b0) begin n_err++; $display("FAIL rd_oob_ack: got %b exp 0", o_play_ack); end
        i_play_req = 1'b1; i_play_addr = 20'd0;
        step(); step();
        i_play_req = 1'b0;
        n_vec++; if (o_play_ack !== 1'b0 || o_sram_oe_n !== 1'b1) begin n_err++; $display("FAIL rd_idle_ignore: ack=%b oe_n=%b exp 0/1", o_play_ack, o_sram_oe_n); end
    endtask

    task automatic test_stop_pause();
        i_key_rec = 1'b1;
        step(); clear_keys();
        n_vec++; if (o_state !== ST_REC || o_end_addr !== 20'd0) begin n_err++; $display("FAIL sp_rec: state=%0d end=%h exp 1/0", o_state, o_end_addr); end
        i_key_stop = 1'b1; i_key_pause = 1'b1;
        step(); clear_keys();
        n_vec++; if (pulses !== 6'b001000 || o_state !== ST_IDLE) begin n_err++; $display("FAIL stop_over_pause: pulses=%b state=%0d exp 001000/0", pulses, o_state); end
    endtask

    task automatic test_max_wrap();
        i_rec_addr = 20'hFFFFF;
        step();
        i_key_rec = 1'b1;
        step(); clear_keys();
        n_vec++; if (o_state !== ST_REC || o_sram_we_n !== 1'b1) begin n_err++; $display("FAIL max_rec: state=%0d we_n=%b exp 1/1", o_state, o_sram_we_n); end
        i_rec_addr = 20'h00000; i_rec_data = 16'hBEEF;
        step();
        n_vec++; if (o_sram_we_n !== 1'b0 || o_sram_addr !== 20'hFFFFF || o_sram_wdata !== 16'hBEEF) begin
            n_err++; $display("FAIL max_wr: we_n=%b addr=%h data=%h exp 0/fffff/beef", o_sram_we_n, o_sram_addr, o_sram_wdata);
        end
        n_vec++; if (o_state !== ST_REC || pulses !== 6'b0) begin n_err++; $display("FAIL max_during: state=%0d pulses=%b exp 1/000000", o_state, pulses); end
        step();
        n_vec++; if (pulses !== 6'b001000 || o_state !== ST_IDLE || o_sram_we_n !== 1'b1) begin
            n_err++; $display("FAIL max_autostop: pulses=%b state=%0d we_n=%b exp 001000/0/1", pulses, o_state, o_sram_we_n);
        end
        n_vec++; if (o_end_addr !== 20'h00000) begin n_err++; $display("FAIL max_end: got %h exp 00000", o_end_addr); end
    endtask

    task automatic test_reset_mid_write();
        i_rec_addr = 20'd0;
        i_key_rec = 1'b1;
        step(); clear_keys();
        i_rec_addr = 20'd1; i_rec_data = 16'h1234;
        step();
        n_vec++; if (o_sram_we_n !== 1'b0 || o_end_addr !== 20'd1) begin n_err++; $display("FAIL mid_wr: we_n=%b end=%h exp 0/1", o_sram_we_n, o_end_addr); end
        i_rst_n = 1'b0;
        #1;
        n_vec++; if (o_sram_we_n !== 1'b1 || o_sram_oe_n !== 1'b1) begin n_err++; $display("FAIL mid_rst_strobe: we_n=%b oe_n=%b exp 1/1", o_sram_we_n, o_sram_oe_n); end
        n_vec++; if (o_end_addr !== 20'd0 || o_state !== ST_IDLE) begin n_err++; $display("FAIL mid_rst_state: end=%h state=%0d exp 0/0", o_end_addr, o_state); end
        step();
        i_rst_n = 1'b1;
        step();
        i_key_play = 1'b1;
        step(); clear_keys();
        n_vec++; if (pulses !== 6'b0 || o_state !== ST_IDLE) begin n_err++; $display("FAIL play_after_rst: pulses=%b state=%0d exp 000000/0", pulses, o_state); end
        step();
    endtask

    task automatic test_strobe_exclusive();
        n_vec++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL strobe_overlap: got %0d cycles exp 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_record();
        test_pause();
        test_play();
        test_stop_pause();
        test_max_wrap();
        test_reset_mid_write();
        test_strobe_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aud_sram_arbiter.md
AUD_SRAM_ARBITER -- requirements
Module: aud_sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SRAM word width.
REQ-003 Parameter MAX_ADDR, default 20'hFFFFF, last writable word address.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_key_rec, i_key_play, i_key_pause, i_key_stop  input  1 each  one-cycle user command pulses.
REQ-007 i_rec_addr  input  ADDR_W  recorder word address; increments when a word completes.
REQ-008 i_rec_data  input  DATA_W  recorder word, valid in the cycle i_rec_addr changes.
REQ-009 i_play_req  input  1  player requests one word; i_play_addr  input  ADDR_W  its address.
REQ-010 o_rec_start, o_rec_pause, o_rec_stop  output  1 each  one-cycle recorder command pulses.
REQ-011 o_play_start, o_play_pause, o_play_stop  output  1 each  one-cycle player command pulses.
REQ-012 o_play_ack  output  1  read data valid; o_play_data  output  DATA_W  read word.
REQ-013 o_sram_addr  output  ADDR_W; o_sram_wdata  output  DATA_W; i_sram_rdata  input  DATA_W.
REQ-014 o_sram_we_n, o_sram_oe_n  output  1 each  active-low SRAM strobes.
REQ-015 o_end_addr  output  ADDR_W  one past last recorded word; o_state  output  3  current FSM state.

Function
REQ-016 FSM states SHALL be IDLE, REC, REC_PAUSE, PLAY, PLAY_PAUSE.
REQ-017 Key priority in any cycle SHALL be stop > pause > rec/play; rec and play together SHALL be ignored.
REQ-018 IDLE: rec -> REC with o_rec_start pulse, o_end_addr cleared to 0; play -> PLAY with o_play_start pulse only if o_end_addr != 0.
REQ-019 REC: pause -> REC_PAUSE (o_rec_pause); stop -> IDLE (o_rec_stop); REC_PAUSE: rec -> REC (o_rec_start), stop -> IDLE (o_rec_stop).
REQ-020 PLAY/PLAY_PAUSE SHALL mirror REQ-019 with play keys and o_play_* pulses.
REQ-021 Command pulses SHALL be registered, asserted the cycle after the key, exactly one cycle wide.
REQ-022 In REC/REC_PAUSE, a cycle with i_rec_addr != its previous registered value SHALL capture write address = previous value and data = i_rec_data.
REQ-023 A captured write SHALL drive o_sram_addr/o_sram_wdata with o_sram_we_n low for exactly one cycle, one cycle after capture; o_end_addr SHALL update to i_rec_addr in that cycle.
REQ-024 A write whose address equals MAX_ADDR SHALL complete, then FSM SHALL go to IDLE with o_rec_stop pulsed automatically.
REQ-025 In PLAY, i_play_req SHALL drive o_sram_addr = i_play_addr, o_sram_oe_n low next cycle; o_play_data = i_sram_rdata with o_play_ack high exactly two cycles after request.
REQ-026 A read request at address >= o_end_addr SHALL not access SRAM; FSM SHALL go to IDLE with o_play_stop pulsed.
REQ-027 i_play_req outside PLAY and while a read is outstanding SHALL be ignored (no ack).
REQ-028 o_sram_we_n and o_sram_oe_n SHALL never be low simultaneously; both high in IDLE and pause states.
REQ-029 Outstanding write/read at a stop key SHALL complete before strobes release; no new access starts.

Reset
REQ-030 On i_rst_n low: state IDLE, all pulses and o_play_ack 0, strobes high, o_sram_addr/o_sram_wdata/o_play_data/o_end_addr 0, previous-address register 0.
REQ-031 Reset mid-access SHALL abort immediately with strobes high; recorded length is lost.

Structure
REQ-032 Shared package aud_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and MAX_ADDR.
REQ-033 SRAM strobe/bus sequencing SHALL be one sub-module aud_sram_port; FSM and key handling stay in the top.

Verification
REQ-034 rec key, i_rec_addr 0->1->2 with data 16'hA5A5, 16'h5A5A -> we_n low at addr 0 then 1, data matched, o_end_addr = 2.
REQ-035 pause during REC then rec -> o_rec_pause then o_rec_start; no writes while paused; o_end_addr unchanged.
REQ-036 play after 2-word record, requests addr 0,1,2 -> acks with 16'hA5A5, 16'h5A5A two cycles later; addr 2 -> o_play_stop, IDLE.
REQ-037 stop and pause same cycle in REC -> IDLE, only o_rec_stop pulsed.
REQ-038 i_rec_addr reaching MAX_ADDR+1 wrap -> write at MAX_ADDR, auto o_rec_stop, IDLE.
REQ-039 reset asserted during a write cycle -> we_n high immediately, o_end_addr 0, play key ignored afterwards.
